// File: rtl/ant_nav_fsm_pkg.sv
// Shared state codes and per-state motion vectors for the ant maze walker.
// Motion vectors are {FW, BW, TLeft, TRight} using right-hand naming.
package ant_nav_fsm_pkg;

  typedef enum logic [2:0] {
    WALL = 3'b000,
    SEEK = 3'b001,
    TURN = 3'b010,
    LOST = 3'b011,
    BACK = 3'b100,
    DONE = 3'b101
  } antState_t;

  localparam logic [3:0] MOT_LOST = 4'b1000;
  localparam logic [3:0] MOT_WALL = 4'b1010;
  localparam logic [3:0] MOT_SEEK = 4'b1001;
  localparam logic [3:0] MOT_TURN = 4'b0010;
  localparam logic [3:0] MOT_BACK = 4'b0100;
  localparam logic [3:0] MOT_DONE = 4'b0000;

  function automatic logic [3:0] motionOf(input antState_t s);
    logic [3:0] m;
    m = MOT_DONE;
    case (s)
      LOST:    m = MOT_LOST;
      WALL:    m = MOT_WALL;
      SEEK:    m = MOT_SEEK;
      TURN:    m = MOT_TURN;
      BACK:    m = MOT_BACK;
      default: m = MOT_DONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ant_dwell_counter.sv
// Saturating up-counter with synchronous clear and count enable; clear wins.
// Used for the per-state dwell timer and the forward-step counter.
module ant_dwell_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ant_nav_fsm.sv
// Two-antenna wall-following maze controller with seek timeout, stuck reverse,
// sticky goal stop, run/pause gate and a saturating forward-step counter.
module ant_nav_fsm
  import ant_nav_fsm_pkg::*;
#(
  parameter int HAND         = 0,
  parameter int LOST_CYCLES  = 1000,
  parameter int STUCK_CYCLES = 500,
  parameter int BACK_CYCLES  = 200,
  parameter int CNT_W        = 16,
  parameter int STEP_W       = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              run,
  input  logic              goal,
  input  logic              LAntenna,
  input  logic              RAntenna,
  output logic              FW,
  output logic              BW,
  output logic              TLeft,
  output logic              TRight,
  output logic [2:0]        antState,
  output logic [STEP_W-1:0] steps
);

  localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(BACK_CYCLES - 1);
  localparam bit MIRROR = (HAND != 0);

  antState_t        curState, nextState, tableState;
  logic [CNT_W-1:0] dwell;
  logic [3:0]       motion;
  logic             wallAnt, farAnt, stateChange;

  assign wallAnt = MIRROR ? LAntenna : RAntenna;
  assign farAnt  = MIRROR ? RAntenna : LAntenna;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      curState <= LOST;
    end else begin
      curState <= nextState;
    end
  end

  always_comb begin
    tableState = farAnt ? TURN : (wallAnt ? WALL : SEEK);
    nextState  = curState;
    if (run) begin
      if (goal) begin
        nextState = DONE;
      end else begin
        case (curState)
          DONE: nextState = DONE;
          LOST: nextState = (tableState == SEEK) ? LOST : tableState;
          SEEK: nextState = ((tableState == SEEK) && (dwell == LOST_LAST)) ? LOST : tableState;
          TURN: nextState = (farAnt && (dwell == STUCK_LAST)) ? BACK : tableState;
          BACK: nextState = (dwell == BACK_LAST) ? tableState : BACK;
          WALL: nextState = tableState;
          default: nextState = LOST;
        endcase
      end
    end
  end

  // nextState only differs from curState when run=1, so pause never clears dwell
  assign stateChange = (nextState != curState);

  ant_dwell_counter #(.W(CNT_W)) dwellCnt (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (stateChange),
    .enable (run),
    .count  (dwell)
  );

  assign motion = motionOf(curState);

  ant_dwell_counter #(.W(STEP_W)) stepCnt (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (1'b0),
    .enable (run & motion[3]),
    .count  (steps)
  );

  assign FW       = run & motion[3];
  assign BW       = run & motion[2];
  assign TLeft    = run & (MIRROR ? motion[0] : motion[1]);
  assign TRight   = run & (MIRROR ? motion[1] : motion[0]);
  assign antState = curState;

endmodule
